// File: rtl/sync_fifo_buf_pkg.sv
// rtl/sync_fifo_buf_pkg.sv - shared defaults, flag bundle and parameter checks for sync_fifo_buf
// Purpose: common definitions imported by sync_fifo_buf and sync_fifo_mem.
// Contents: default SIZE/DEPTH/AF_LEVEL, registered status flag struct,
//           power-of-two and parameter-legality helpers used at elaboration.
package sync_fifo_buf_pkg;

  localparam int DEF_SIZE     = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_AF_LEVEL = 3;

  // Status flags are registered together from the next-state count.
  typedef struct packed {
    logic empty;
    logic full;
    logic afull;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{empty: 1'b1, full: 1'b0, afull: 1'b0};

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Pointer wrap relies on DEPTH being a power of two; DEPTH=1 would give
  // zero-width pointers.
  function automatic bit fifo_params_ok(input int depth, input int af_level);
    return is_pow2(depth) && (depth >= 2) && (af_level >= 1) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x SIZE register array, sync write, async read
// Purpose: storage for sync_fifo_buf. The array has no reset; contents survive rst.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address ($clog2(DEPTH) bits)
//   wdata  in   write data (SIZE bits)
//   raddr  in   read address ($clog2(DEPTH) bits)
//   rdata  out  combinational read data (SIZE bits)
module sync_fifo_mem
  import sync_fifo_buf_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [SIZE-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [SIZE-1:0]          rdata
);

  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A simultaneous write and read to the same address returns the old
  // contents, which is what the full-buffer read/write case needs.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_buf.sv
// rtl/sync_fifo_buf.sv - single-clock DEPTH-entry FIFO with flags, count and error pulses
// Purpose: buffers SIZE-bit words between a producer and consumer in one clock domain.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   w_data     in   write data
//   w_en       in   write request
//   w_full     out  buffer full (registered)
//   w_afull    out  count >= AF_LEVEL (registered)
//   r_en       in   read request
//   r_data     out  read data, registered, valid the cycle after an accepted read
//   r_empty    out  buffer empty (registered)
//   count      out  occupancy 0..DEPTH
//   overflow   out  1-cycle pulse: write rejected
//   underflow  out  1-cycle pulse: read rejected
module sync_fifo_buf
  import sync_fifo_buf_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SIZE-1:0]        w_data,
  input  logic                   w_en,
  output logic                   w_full,
  output logic                   w_afull,
  input  logic                   r_en,
  output logic [SIZE-1:0]        r_data,
  output logic                   r_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  if (!fifo_params_ok(DEPTH, AF_LEVEL)) begin : g_param_err
    $error("sync_fifo_buf: DEPTH must be a power of two >= 2 and 1 <= AF_LEVEL <= DEPTH");
  end

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  fifo_flags_t       flags_q;
  fifo_flags_t       flags_d;
  logic [SIZE-1:0]   mem_rdata;
  logic [SIZE-1:0]   r_data_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              rd_ok;
  logic              wr_ok;

  // A read frees a slot in the same cycle, so a full buffer still takes a
  // write when a read is accepted alongside it.
  assign rd_ok = r_en & ~flags_q.empty;
  assign wr_ok = w_en & (~flags_q.full | rd_ok);

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    flags_d.empty = (cnt_d == '0);
    flags_d.full  = (cnt_d == FULL_CNT);
    flags_d.afull = (cnt_d >= AF_CNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      cnt_q       <= '0;
      flags_q     <= FLAGS_RESET;
      r_data_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      overflow_q  <= w_en & ~wr_ok;
      underflow_q <= r_en & ~rd_ok;
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr     <= rptr + PTR_ONE;
        r_data_q <= mem_rdata;
      end
    end
  end

  sync_fifo_mem #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (w_data),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  assign count     = cnt_q;
  assign r_empty   = flags_q.empty;
  assign w_full    = flags_q.full;
  assign w_afull   = flags_q.afull;
  assign r_data    = r_data_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
